mips_sequencer: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It replaces the free-running state counter: it owns the PC and emits the 3-bit state code consumed by fetch, regfile, executer and memory. It also skips stages per opcode, waits on memory readiness, resolves branches and jumps, counts retired instructions, and halts on a HALT opcode or the end of instruction memory.

---
 rtl/mips_sequencer_if.sv | 28 ++
 rtl/mips_sequencer.sv | 123 ++++++++++++
 tb/tb_mips_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer is the slave: it consumes decode/handshake inputs and drives state, pc and strobes.
interface mips_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic [15:0]      imm;
  logic [25:0]      jaddr;
  logic             alu_zero;
  logic             mem_ready;
  logic [2:0]       state;
  logic [PC_W-1:0]  pc;
  logic             reg_we;
  logic             mem_we;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output opcode, imm, jaddr, alu_zero, mem_ready,
    input  state, pc, reg_we, mem_we, halted, retired
  );

  modport slave (
    input  opcode, imm, jaddr, alu_zero, mem_ready,
    output state, pc, reg_we, mem_we, halted, retired
  );
endinterface

// File: rtl/mips_sequencer.sv
// Multi-cycle MIPS control sequencer: owns the PC, skips stages per opcode, waits on memory,
// resolves branches/jumps, counts retired instructions and halts on HALT or end of imem.
module mips_sequencer #(
  parameter int PC_W       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  mips_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_OUTPUT    = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             reg_we_q, reg_we_d;
  logic             mem_we_q, mem_we_d;
  logic             halted_q, halted_d;

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  branch_off;
  logic [PC_W-1:0]  jump_target;

  assign pc_inc      = pc_q + PC_W'(1);
  assign branch_off  = {{(PC_W-16){bus.imm[15]}}, bus.imm};
  assign jump_target = {{(PC_W-26){1'b0}}, bus.jaddr};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    retired_d = retired_q;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      // Opcode is captured here so later stages do not depend on the decode bus staying stable.
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = (bus.opcode == OP_HALT) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        pc_d = pc_inc;
        case (op_q)
          OP_LW, OP_SW:      state_d = S_MEMORY;
          OP_RTYPE, OP_ADDI: state_d = S_WRITEBACK;
          OP_BEQ: begin
            if (bus.alu_zero) pc_d = pc_inc + branch_off;
            state_d = S_OUTPUT;
          end
          OP_J: begin
            pc_d    = jump_target;
            state_d = S_OUTPUT;
          end
          default:           state_d = S_OUTPUT;
        endcase
      end
      S_MEMORY: begin
        if (bus.mem_ready) state_d = (op_q == OP_SW) ? S_OUTPUT : S_WRITEBACK;
      end
      S_WRITEBACK: state_d = S_OUTPUT;
      // pc already holds the next instruction index, so the bound check uses it directly.
      S_OUTPUT: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = (pc_q >= PC_W'(IMEM_DEPTH)) ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    reg_we_d = (state_d == S_WRITEBACK);
    mem_we_d = (state_d == S_MEMORY) && (op_d == OP_SW);
    halted_d = halted_q || (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      op_q      <= '0;
      retired_q <= '0;
      reg_we_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      reg_we_q  <= reg_we_d;
      mem_we_q  <= mem_we_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.pc      = pc_q;
  assign bus.reg_we  = reg_we_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mips_sequencer.sv
// Directed and randomized checks of mips_sequencer against an instruction-level model
// that expands each instruction into its expected per-cycle state trace.
module tb_mips_sequencer;
  localparam int PC_W       = 32;
  localparam int IMEM_DEPTH = 64;
  localparam int CNT_W      = 16;

  localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4, ST_O = 5, ST_H = 6;
  localparam int RDY_LO = 0, RDY_HI = 1, RDY_ANY = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  mips_sequencer #(.PC_W(PC_W), .IMEM_DEPTH(IMEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_pc;
  logic [15:0] m_ret;
  bit          m_halted;

  int exp_st[$];
  int exp_rdy[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] next_pc(input logic [5:0] op, input logic [15:0] im,
                                          input logic [25:0] ja, input bit z);
    logic [31:0] off;
    off = 32'(int'($signed(im)));
    case (op)
      6'h04:   return z ? (m_pc + 32'd1 + off) : (m_pc + 32'd1);
      6'h02:   return {6'd0, ja};
      6'h3F:   return m_pc;
      default: return m_pc + 32'd1;
    endcase
  endfunction

  // Expand one instruction into its cycle-by-cycle state trace and mem_ready requirements.
  task automatic build(input logic [5:0] op, input int fw, input int mw, input logic [31:0] pc_new);
    exp_st.delete();
    exp_rdy.delete();
    for (int k = 0; k < fw; k++) begin exp_st.push_back(ST_F); exp_rdy.push_back(RDY_LO); end
    exp_st.push_back(ST_F); exp_rdy.push_back(RDY_HI);
    exp_st.push_back(ST_D); exp_rdy.push_back(RDY_ANY);
    if (op == 6'h3F) begin
      for (int k = 0; k < 3; k++) begin exp_st.push_back(ST_H); exp_rdy.push_back(RDY_ANY); end
      return;
    end
    exp_st.push_back(ST_E); exp_rdy.push_back(RDY_ANY);
    if (op == 6'h23 || op == 6'h2B) begin
      for (int k = 0; k < mw; k++) begin exp_st.push_back(ST_M); exp_rdy.push_back(RDY_LO); end
      exp_st.push_back(ST_M); exp_rdy.push_back(RDY_HI);
    end
    if (op == 6'h23 || op == 6'h00 || op == 6'h08) begin
      exp_st.push_back(ST_W); exp_rdy.push_back(RDY_ANY);
    end
    exp_st.push_back(ST_O); exp_rdy.push_back(RDY_ANY);
    if (pc_new >= 32'(IMEM_DEPTH)) begin
      for (int k = 0; k < 3; k++) begin exp_st.push_back(ST_H); exp_rdy.push_back(RDY_ANY); end
    end
  endtask

  // Runs from a negedge at the start of FETCH; stop >= 0 aborts after that many cycles.
  task automatic run_instr(input logic [5:0] op, input logic [15:0] im, input logic [25:0] ja,
                           input bit z, input int fw, input int mw, input int stop);
    logic [31:0] pc_new;
    bit after_e, after_o;
    int n, st;
    pc_new = next_pc(op, im, ja, z);
    build(op, fw, mw, pc_new);
    n = exp_st.size();
    if (stop >= 0 && stop < n) n = stop;
    after_e = 0;
    after_o = 0;
    for (int i = 0; i < n; i++) begin
      st = exp_st[i];
      check($sformatf("state op=%0h cyc=%0d", op, i), 32'(bus.state), 32'(st));
      check($sformatf("pc op=%0h cyc=%0d", op, i), bus.pc, after_e ? pc_new : m_pc);
      check($sformatf("retired op=%0h cyc=%0d", op, i), 32'(bus.retired),
            32'(after_o ? m_ret + 16'd1 : m_ret));
      check($sformatf("reg_we op=%0h cyc=%0d", op, i), 32'(bus.reg_we), 32'(st == ST_W));
      check($sformatf("mem_we op=%0h cyc=%0d", op, i), 32'(bus.mem_we),
            32'(st == ST_M && op == 6'h2B));
      check($sformatf("halted op=%0h cyc=%0d", op, i), 32'(bus.halted), 32'(st == ST_H));
      bus.opcode    = (st == ST_F) ? 6'($urandom) : op;
      bus.imm       = im;
      bus.jaddr     = ja;
      bus.alu_zero  = (st == ST_E) ? z : 1'($urandom);
      bus.mem_ready = (exp_rdy[i] == RDY_ANY) ? 1'($urandom) : (exp_rdy[i] == RDY_HI);
      @(negedge clk);
      if (st == ST_E) after_e = 1;
      if (st == ST_O) after_o = 1;
    end
    if (n == exp_st.size()) begin
      if (op != 6'h3F) begin
        m_pc  = pc_new;
        m_ret = m_ret + 16'd1;
      end
      m_halted = (op == 6'h3F) || (pc_new >= 32'(IMEM_DEPTH));
    end
    $display("instr op=%02h imm=%04h jaddr=%0d z=%0d fw=%0d mw=%0d -> pc=%0d retired=%0d halted=%0d",
             op, im, ja, z, fw, mw, m_pc, m_ret, m_halted);
  endtask

  // Reset asserted between clock edges: outputs must clear without any edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst state",   32'(bus.state),   32'd0);
    check("rst pc",      bus.pc,           32'd0);
    check("rst retired", 32'(bus.retired), 32'd0);
    check("rst reg_we",  32'(bus.reg_we),  32'd0);
    check("rst mem_we",  32'(bus.mem_we),  32'd0);
    check("rst halted",  32'(bus.halted),  32'd0);
    @(negedge clk);
    reset    = 1'b0;
    m_pc     = '0;
    m_ret    = '0;
    m_halted = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [15:0] im;
    int          pick;

    bus.opcode = '0; bus.imm = '0; bus.jaddr = '0; bus.alu_zero = 0; bus.mem_ready = 0;
    @(negedge clk);
    do_reset();

    // Reset in the middle of a stalled SW at pc=4 (pc already advanced to 5, retired=3).
    run_instr(6'h11, 16'h0, 26'd0, 0, 1, 0, -1);
    run_instr(6'h11, 16'h0, 26'd0, 0, 0, 0, -1);
    run_instr(6'h02, 16'h0, 26'd4, 0, 0, 0, -1);
    run_instr(6'h2B, 16'h0, 26'd0, 0, 0, 3, 5);
    check("midmem state",   32'(bus.state),   32'd3);
    check("midmem pc",      bus.pc,           32'd5);
    check("midmem retired", 32'(bus.retired), 32'd3);
    check("midmem mem_we",  32'(bus.mem_we),  32'd1);
    do_reset();

    run_instr(6'h00, 16'h0, 26'd0, 0, 0, 0, -1);     // R at pc 0
    run_instr(6'h11, 16'h0, 26'd0, 0, 0, 0, -1);     // unknown -> NOP
    run_instr(6'h23, 16'h0, 26'd0, 0, 0, 3, -1);     // LW at pc 2, 3 wait cycles
    run_instr(6'h08, 16'h0, 26'd0, 0, 2, 0, -1);     // ADDI with fetch waits
    run_instr(6'h02, 16'h0, 26'd10, 0, 0, 0, -1);
    run_instr(6'h04, 16'hFFFC, 26'd0, 1, 0, 0, -1);  // BEQ taken -> 7
    run_instr(6'h02, 16'h0, 26'd10, 0, 0, 0, -1);
    run_instr(6'h04, 16'hFFFC, 26'd0, 0, 0, 0, -1);  // BEQ not taken -> 11
    run_instr(6'h02, 16'h0, 26'd63, 0, 0, 0, -1);    // J 63
    run_instr(6'h11, 16'h0, 26'd0, 0, 0, 0, -1);     // pc -> 64 -> HALT
    do_reset();
    run_instr(6'h02, 16'h0, 26'd4, 0, 0, 0, -1);
    run_instr(6'h3F, 16'h0, 26'd0, 0, 0, 0, -1);     // HALT opcode at pc 4
    do_reset();
    run_instr(6'h04, 16'hFFF0, 26'd0, 1, 0, 0, -1);  // branch below 0 wraps -> HALT
    do_reset();

    for (int t = 0; t < 250; t++) begin
      pick = int'($urandom_range(0, 19));
      case (pick)
        0, 1, 2:    op = 6'h00;
        3, 4:       op = 6'h08;
        5, 6, 7:    op = 6'h23;
        8, 9, 10:   op = 6'h2B;
        11, 12, 13: op = 6'h04;
        14, 15:     op = 6'h02;
        16:         op = 6'h3F;
        default:    op = 6'($urandom_range(0, 62));
      endcase
      im = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($signed(int'($urandom_range(0, 16)) - 8));
      run_instr(op, im, 26'($urandom_range(0, 63)), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      if (m_halted) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
